// File: rtl/gemm_pkg.sv
// Purpose: shared GEMM datapath constants and the weight-buffer sequencer state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gemm_pkg;

  // Default datapath geometry used across the GEMM blocks
  localparam int GEMM_DATA_WIDTH = 16;
  localparam int GEMM_DEPTH      = 512;
  localparam int GEMM_N_COLS     = 8;

  // Weight-buffer sequencer state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_REWIND = 3'd4;
  localparam logic [2:0] ST_READY  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLR    = ST_CLR,
    S_LOAD   = ST_LOAD,
    S_RUN    = ST_RUN,
    S_REWIND = ST_REWIND,
    S_READY  = ST_READY
  } wb_state_e;

endpackage

// File: rtl/gemm_w_buff.sv
// Purpose: one PE-column weight buffer; sequential pointer, write or read-advance per valid.
// Latency: write lands at the clock edge; read is asynchronous at the current pointer.
// Backpressure: none; every i_valid cycle advances the pointer.
// Ports: i_clk clock; i_rst synchronous pointer clear; i_valid advance pointer;
//        i_write store i_data at pointer when i_valid; o_data entry at pointer.
module gemm_w_buff
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int DEPTH      = GEMM_DEPTH,
  parameter int N_DEPTH    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam logic [N_DEPTH-1:0] PTR_LAST = N_DEPTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [N_DEPTH-1:0]    ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (i_valid) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_valid && i_write) begin
      mem[ptr] <= i_data;
    end
  end

  assign o_data = mem[ptr];

endmodule

// File: rtl/gemm_w_buff_ctrl.sv
// Purpose: loads a weight stream column by column into the per-column buffers, then replays them in lock-step.
// Latency: beat written in its accept cycle; done pulses one cycle after the last step; READY the cycle after.
// Backpressure: o_w_ready high only in LOAD; i_step gates the replay, buffers hold while it is low.
// Ports: i_load/i_run requests with i_len; i_w_valid/i_w_data/o_w_ready weight stream; i_step array consume;
//        o_buf_* drive the N_COLS buffers; o_loaded/o_busy status; o_done/o_err single-cycle pulses.
module gemm_w_buff_ctrl
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int DEPTH      = GEMM_DEPTH,
  parameter int N_COLS     = GEMM_N_COLS,
  parameter int N_DEPTH    = $clog2(DEPTH),
  parameter int N_COLW     = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [N_DEPTH:0]      i_len,
  input  logic                  i_w_valid,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic                  o_w_ready,
  input  logic                  i_run,
  input  logic                  i_step,
  output logic                  o_buf_rst,
  output logic [N_COLS-1:0]     o_buf_valid,
  output logic [N_COLS-1:0]     o_buf_write,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  output logic                  o_loaded,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  // Length counters carry one extra bit so len == DEPTH is representable
  localparam logic [N_DEPTH:0]  LEN_MAX  = (N_DEPTH + 1)'(DEPTH);
  localparam logic [N_DEPTH:0]  LEN_ONE  = (N_DEPTH + 1)'(1);
  localparam logic [N_COLW-1:0] COL_LAST = N_COLW'(N_COLS - 1);

  wb_state_e         state, state_nxt;
  logic [N_DEPTH:0]  len_q;
  logic [N_DEPTH:0]  ent_q;      // entry index in LOAD, step count in RUN
  logic [N_COLW-1:0] col_q;
  logic              from_load_q; // REWIND follows a load (else a pass)
  logic              loaded_q;

  logic              len_ok;
  logic              at_rest;
  logic              take_load;
  logic              take_run;
  logic              beat;
  logic              step;
  logic              ent_last;
  logic [N_COLS-1:0] col_onehot;

  assign len_ok    = (i_len != '0) && (i_len <= LEN_MAX);
  assign at_rest   = (state == S_IDLE) || (state == S_READY);
  // Load has priority over run when both are requested together
  assign take_load = at_rest && i_load && len_ok;
  assign take_run  = (state == S_READY) && !i_load && i_run && len_ok;
  assign beat      = (state == S_LOAD) && i_w_valid;
  assign step      = (state == S_RUN) && i_step;
  assign ent_last  = (ent_q == (len_q - LEN_ONE));

  always_comb begin
    col_onehot = '0;
    for (int c = 0; c < N_COLS; c++) begin
      col_onehot[c] = (col_q == N_COLW'(c));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_w_ready   = 1'b0;
    o_buf_rst   = 1'b0;
    o_buf_valid = '0;
    o_buf_write = '0;
    o_buf_data  = '0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_loaded    = loaded_q;

    case (state)
      S_IDLE, S_READY: begin
        o_busy = 1'b0;
        if (take_load) begin
          state_nxt = S_CLR;
        end else if (take_run) begin
          state_nxt = S_RUN;
        end
        // A run in IDLE is ignored outright, so it never flags a bad length
        o_err = !len_ok && (i_load || (i_run && state == S_READY));
      end
      S_CLR: begin
        o_buf_rst = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_w_ready = 1'b1;
        if (beat) begin
          o_buf_valid = col_onehot;
          o_buf_write = col_onehot;
          o_buf_data  = i_w_data;
          if (ent_last && col_q == COL_LAST) begin
            state_nxt = S_REWIND;
          end
        end
      end
      S_RUN: begin
        if (step) begin
          o_buf_valid = '1;
          if (ent_last) begin
            state_nxt = S_REWIND;
          end
        end
      end
      S_REWIND: begin
        o_buf_rst = 1'b1;
        o_done    = !from_load_q;
        state_nxt = S_READY;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // While reset is held the buffers are kept cleared and everything else is quiet
    if (!i_rst_n) begin
      state_nxt   = S_IDLE;
      o_w_ready   = 1'b0;
      o_buf_rst   = 1'b1;
      o_buf_valid = '0;
      o_buf_write = '0;
      o_buf_data  = '0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_err       = 1'b0;
      o_loaded    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_q       <= '0;
      ent_q       <= '0;
      col_q       <= '0;
      from_load_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (take_load) begin
            len_q       <= i_len;
            loaded_q    <= 1'b0;
            from_load_q <= 1'b1;
          end else if (take_run) begin
            len_q       <= i_len;
            ent_q       <= '0;
            from_load_q <= 1'b0;
          end
        end
        S_CLR: begin
          ent_q <= '0;
          col_q <= '0;
        end
        S_LOAD: begin
          if (beat) begin
            if (ent_last) begin
              ent_q <= '0;
              col_q <= col_q + 1'b1;
            end else begin
              ent_q <= ent_q + LEN_ONE;
            end
          end
        end
        S_RUN: begin
          if (step) begin
            ent_q <= ent_last ? '0 : ent_q + LEN_ONE;
          end
        end
        S_REWIND: begin
          ent_q <= '0;
          col_q <= '0;
          if (from_load_q) begin
            loaded_q <= 1'b1;
          end
        end
        default: begin
          ent_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_w_buff_ctrl.sv
module tb_gemm_w_buff_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 512;
  localparam int NC    = 4;
  localparam int ND    = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_load, i_run, i_step, i_w_valid;
  logic [ND:0]   i_len;
  logic [DW-1:0] i_w_data;
  logic          w_ready, buf_rst, loaded, busy, done, err;
  logic [NC-1:0] buf_valid, buf_write;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] bq [NC];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]      model [NC][DEPTH];
  logic [NC*DW-1:0]   sb_q [$];

  typedef struct {
    logic        load;
    logic        run;
    logic [ND:0] len;
    logic        exp_err;
    logic        exp_busy;
    logic        exp_loaded;
  } vec_t;

  vec_t tbl_idle  [5];
  vec_t tbl_ready [5];

  always #5 clk = ~clk;

  gemm_w_buff_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .N_COLS(NC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(i_load), .i_len(i_len),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(w_ready),
    .i_run(i_run), .i_step(i_step), .o_buf_rst(buf_rst),
    .o_buf_valid(buf_valid), .o_buf_write(buf_write), .o_buf_data(buf_data),
    .o_loaded(loaded), .o_busy(busy), .o_done(done), .o_err(err)
  );

  for (genvar c = 0; c < NC; c++) begin : g_buf
    gemm_w_buff #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_buf (
      .i_clk(clk), .i_rst(buf_rst), .i_valid(buf_valid[c]),
      .i_write(buf_write[c]), .i_data(buf_data), .o_data(bq[c])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*DW-1:0] row(input int k);
    return {model[3][k], model[2][k], model[1][k], model[0][k]};
  endfunction

  function automatic logic [NC*DW-1:0] got_row();
    return {bq[3], bq[2], bq[1], bq[0]};
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    i_load = v.load; i_run = v.run; i_len = v.len;
    #1;
    check({tag, "_err"}, 64'(err), 64'(v.exp_err));
    cyc();
    i_load = 1'b0; i_run = 1'b0;
    #1;
    check({tag, "_busy"}, 64'(busy), 64'(v.exp_busy));
    check({tag, "_loaded"}, 64'(loaded), 64'(v.exp_loaded));
  endtask

  // stop_after >= 0 abandons the stream after that many beats (left in LOAD)
  task automatic do_load(input int len, input logic [DW-1:0] base, input bit stall,
                         input bit with_run, input int stop_after);
    int beat = 0, cycles = 0, bad = 0;
    logic v;
    logic [NC-1:0] exp_wr;
    i_load = 1'b1; i_run = with_run; i_len = (ND+1)'(len);
    #1;
    check("load_req_err", 64'(err), 64'd0);
    cyc();
    i_load = 1'b0; i_run = 1'b0;
    #1;
    check("clr_buf_rst", 64'(buf_rst), 64'd1);
    check("clr_loaded", 64'(loaded), 64'd0);
    check("clr_busy", 64'(busy), 64'd1);
    check("clr_w_ready", 64'(w_ready), 64'd0);
    cyc();
    while (beat < NC * len && cycles < 8 * len + 20) begin
      if (stop_after >= 0 && beat == stop_after) begin
        i_w_valid = 1'b0;
        return;
      end
      v = stall ? (cycles % 2 == 0) : 1'b1;
      i_w_valid = v;
      i_w_data  = base + DW'(beat);
      #1;
      exp_wr = v ? (NC'(1) << (beat / len)) : '0;
      if (!w_ready || buf_write !== exp_wr || buf_valid !== exp_wr ||
          (v && buf_data !== i_w_data) || buf_rst)
        bad++;
      if (v && w_ready) begin
        model[beat / len][beat % len] = base + DW'(beat);
        beat++;
      end
      cyc();
      cycles++;
    end
    i_w_valid = 1'b0;
    check("load_beats", 64'(beat), 64'(NC * len));
    check("load_bad_cycles", 64'(bad), 64'd0);
    if (!stall) check("load_cycles", 64'(cycles), 64'(NC * len));
    #1;
    check("rewind_buf_rst", 64'(buf_rst), 64'd1);
    check("rewind_loaded", 64'(loaded), 64'd0);
    check("rewind_busy", 64'(busy), 64'd1);
    check("rewind_no_done", 64'(done), 64'd0);
    cyc();
    check("ready_loaded", 64'(loaded), 64'd1);
    check("ready_busy", 64'(busy), 64'd0);
    check("ready_ptr0", got_row(), row(0));
  endtask

  // pat bit i is i_step in pass cycle i; beyond patlen steps are continuous
  task automatic do_run(input int len, input logic [15:0] pat, input int patlen, input int stop_after);
    int steps = 0, i = 0, bad = 0;
    logic s;
    i_run = 1'b1; i_len = (ND+1)'(len);
    #1;
    check("run_req_err", 64'(err), 64'd0);
    cyc();
    i_run = 1'b0;
    for (int k = 0; k < len; k++) sb_q.push_back(row(k));
    while (steps < len && i < 4 * len + 20) begin
      if (stop_after >= 0 && steps == stop_after) begin
        i_step = 1'b0;
        sb_q.delete();
        return;
      end
      s = (i < patlen) ? pat[i] : 1'b1;
      i_step = s;
      #1;
      if (s) begin
        check("run_data", got_row(), sb_q.pop_front());
        if (buf_valid !== '1) bad++;
      end else begin
        check("hold_data", got_row(), sb_q[0]);
        if (buf_valid !== '0) bad++;
      end
      if (buf_write !== '0 || done || !busy || buf_rst) bad++;
      if (s) steps++;
      cyc();
      i++;
    end
    i_step = 1'b0;
    check("run_steps", 64'(steps), 64'(len));
    check("run_sb_empty", 64'(sb_q.size()), 64'd0);
    check("run_bad_cycles", 64'(bad), 64'd0);
    #1;
    check("pass_done", 64'(done), 64'd1);
    check("pass_buf_rst", 64'(buf_rst), 64'd1);
    check("pass_busy", 64'(busy), 64'd1);
    cyc();
    check("after_done_low", 64'(done), 64'd0);
    check("after_busy", 64'(busy), 64'd0);
    check("after_loaded", 64'(loaded), 64'd1);
    check("after_ptr0", got_row(), row(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl_idle[0]  = '{1'b1, 1'b0, 10'd0,    1'b1, 1'b0, 1'b0};
    tbl_idle[1]  = '{1'b1, 1'b0, 10'd513,  1'b1, 1'b0, 1'b0};
    tbl_idle[2]  = '{1'b0, 1'b1, 10'd3,    1'b0, 1'b0, 1'b0};
    tbl_idle[3]  = '{1'b0, 1'b1, 10'd0,    1'b0, 1'b0, 1'b0};
    tbl_idle[4]  = '{1'b1, 1'b0, 10'd1023, 1'b1, 1'b0, 1'b0};
    tbl_ready[0] = '{1'b1, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1};
    tbl_ready[1] = '{1'b1, 1'b0, 10'd513,  1'b1, 1'b0, 1'b1};
    tbl_ready[2] = '{1'b0, 1'b1, 10'd0,    1'b1, 1'b0, 1'b1};
    tbl_ready[3] = '{1'b0, 1'b1, 10'd600,  1'b1, 1'b0, 1'b1};
    tbl_ready[4] = '{1'b1, 1'b1, 10'd0,    1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; i_load = 1'b0; i_run = 1'b0; i_step = 1'b0;
    i_w_valid = 1'b0; i_w_data = '0; i_len = '0;
    cyc();
    cyc();
    check("reset_buf_rst", 64'(buf_rst), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_loaded", 64'(loaded), 64'd0);
    check("reset_w_ready", 64'(w_ready), 64'd0);
    check("reset_done_err", 64'({done, err}), 64'd0);
    rst_n = 1'b1;
    cyc();
    check("idle_buf_rst", 64'(buf_rst), 64'd0);

    for (int i = 0; i < 5; i++) apply_vec(tbl_idle[i], $sformatf("idle_vec%0d", i));

    do_load(3, 16'h0001, 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) apply_vec(tbl_ready[i], $sformatf("ready_vec%0d", i));

    do_run(3, 16'h0000, 0, -1);
    do_run(3, 16'h0000, 0, -1);
    do_run(3, 16'b11001, 5, -1);

    // load+run together in READY: load wins, stalled stream
    do_load(3, 16'h0100, 1'b1, 1'b1, -1);
    do_run(3, 16'b0110, 4, -1);

    do_load(DEPTH, 16'h1000, 1'b0, 1'b0, -1);
    do_run(DEPTH, 16'h0000, 0, -1);
    do_run(5, 16'b101, 3, -1);

    // reset in the middle of a load
    do_load(3, 16'h0200, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("midload_rst_buf_rst", 64'(buf_rst), 64'd1);
    check("midload_rst_w_ready", 64'(w_ready), 64'd0);
    cyc();
    check("midload_rst_loaded", 64'(loaded), 64'd0);
    check("midload_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cyc();
    check("midload_ptr0", got_row(), row(0));

    // reset in the middle of a pass
    do_load(3, 16'h0300, 1'b0, 1'b0, -1);
    do_run(3, 16'h0000, 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_buf_rst", 64'(buf_rst), 64'd1);
    check("midrun_rst_valid", 64'(buf_valid), 64'd0);
    cyc();
    check("midrun_rst_loaded", 64'(loaded), 64'd0);
    check("midrun_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cyc();
    check("midrun_ptr0", got_row(), row(0));
    i_run = 1'b1; i_len = 10'd3;
    #1;
    check("idle_run_err", 64'(err), 64'd0);
    cyc();
    i_run = 1'b0;
    #1;
    check("idle_run_ignored", 64'(busy), 64'd0);
    check("idle_run_loaded", 64'(loaded), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_w_buff_ctrl.md
# gemm_w_buff_ctrl

Sequencer for the bank of per-column weight buffers (`gemm_w_buff`) feeding the GEMM PE array. It loads a weight stream column by column through a valid/ready handshake, then replays the stored entries to all columns in lock-step, one entry per array step. It rewinds the buffer pointers after every load and every pass, so any pass length up to `DEPTH` works. It sits between the weight DMA/stream source and the `N_COLS` buffer instances.

## Interface

- `DATA_WIDTH`, 16: weight word width.
- `DEPTH`, 512: entries per column buffer.
- `N_COLS`, 8: PE array columns, one buffer each.
- `N_DEPTH`, `$clog2(DEPTH)`: entry index width.
- `N_COLW`, `max(1,$clog2(N_COLS))`: column index width.

- `i_clk` in 1: clock.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_load` in 1: request load of a new weight set.
- `i_len` in `N_DEPTH+1`: entries per column. Sampled on accepted `i_load` or `i_run`. Legal range 1..`DEPTH`.
- `i_w_valid` in 1: weight beat valid.
- `i_w_data` in `DATA_WIDTH`: weight beat.
- `o_w_ready` out 1: controller accepts a beat.
- `i_run` in 1: request one replay pass.
- `i_step` in 1: PE array consumes the current entry.
- `o_buf_rst` out 1: to every buffer's `i_rst`. Zeroes the pointers.
- `o_buf_valid` out `N_COLS`: per-column `i_valid`.
- `o_buf_write` out `N_COLS`: per-column `i_write`.
- `o_buf_data` out `DATA_WIDTH`: shared `i_data` for all buffers.
- `o_loaded` out 1: a complete weight set is resident.
- `o_busy` out 1: state is not IDLE or READY.
- `o_done` out 1: one-cycle pulse at the end of a pass.
- `o_err` out 1: one-cycle pulse when a request has an illegal `i_len`.

## Operation

- States: IDLE, CLR, LOAD, RUN, REWIND, READY.
- Reset values: state IDLE, `o_buf_rst`=1 while `i_rst_n`=0. All other outputs 0, counters 0.
- **IDLE / READY, on `i_load`:**
  - If `i_len` is 0 or greater than `DEPTH`: pulse `o_err` and stay in the current state.
  - Otherwise: latch `len`, clear `o_loaded`, go to CLR.
- **IDLE / READY, `i_load` and `i_run` together:** `i_load` wins.
- **READY, on `i_run` with legal `i_len`:** latch `len` and go to RUN. `i_run` in IDLE is ignored.
- **CLR:** `o_buf_rst`=1 for exactly one cycle, then LOAD with `col`=0, `ent`=0.
- **LOAD:**
  - `o_w_ready`=1.
  - On a beat (`i_w_valid & o_w_ready`): `o_buf_write[col]`=`o_buf_valid[col]`=1 and `o_buf_data`=`i_w_data` in the same cycle. Only that column is written.
  - `ent` increments per beat. At `ent==len-1`, `ent`←0 and `col`++.
  - The beat at `col==N_COLS-1`, `ent==len-1` moves the state to REWIND (from load).
  - Total beats accepted: `N_COLS*len`. Idle cycles inside the stream are allowed.
- **RUN:**
  - `o_buf_valid` = all-ones when `i_step`=1, else 0. `o_buf_write`=0.
  - Step counter increments per step. The step with count==`len-1` moves the state to REWIND (from run).
  - When `i_step`=0, all buffers hold their pointer.
- **REWIND:**
  - `o_buf_rst`=1 for one cycle.
  - After a load: set `o_loaded`=1 and go to READY.
  - After a run: `o_done`=1 this cycle, go to READY.
- **Ignored requests:** `i_load` and `i_run` outside IDLE/READY are ignored. A new request needs a fresh assertion after READY is reached.
- **Reset mid-operation:** return to IDLE, `o_loaded`=0. Buffer pointers are cleared by the reset-driven `o_buf_rst`.
- **Counter widths:** `ent` and step counter are `N_DEPTH+1` bits so `len`=`DEPTH` does not alias. `col` is `N_COLW` bits.

## Timing

- Write path is combinational: a beat accepted in cycle t is written at the end of cycle t, with zero added latency.
- The buffer read is asynchronous. In RUN, entry k is visible on every buffer's `o_data` before step k, and entry 0 is visible from the first RUN cycle.
- Pass latency:
  - Last step in cycle t.
  - REWIND and `o_done` in t+1.
  - READY in t+2, the earliest cycle a new `i_run` is accepted.
- Load latency: accepted `i_load` in t → CLR t+1 → LOAD from t+2. The final beat in cycle u gives REWIND at u+1 and `o_loaded` high from u+2.
- `o_busy` is high in CLR, LOAD, RUN and REWIND.

## Structure

- Shared package `gemm_pkg` holds:
  - the state encoding localparams;
  - the default `DATA_WIDTH`/`DEPTH`/`N_COLS` constants used across the GEMM datapath.
- Single module with no sub-module. Counters and the FSM are inline.
- The bench instantiates `N_COLS` real `gemm_w_buff` instances behind it.

## Test plan

- Reset, then load with `N_COLS`=4, `len`=3, words 0x0001..0x000C, no stalls → `o_w_ready` high for 12 beats, one-hot `o_buf_write` per column, `o_loaded` at beat12+2 cycles.
- Run `len`=3 with `i_step` continuous → each column reads its 3 words in order, `o_done` 1 cycle after step 3. A second run replays identical data.
- Run with `i_step` pattern 1,0,0,1,1 → buffer outputs hold during gaps, `o_done` after the 3rd step.
- `len`=`DEPTH`=512 load and run → no alias, pointers back to 0 after REWIND.
- `i_load` with `i_len`=0, then 513 → `o_err` pulses, state and `o_loaded` unchanged. `i_load`+`i_run` in READY → load taken.
- Assert `i_rst_n`=0 mid-LOAD and mid-RUN → IDLE, `o_loaded`=0, `o_buf_rst`=1 during reset.
